// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: loads a length-prefixed byte stream into BRAM,
// then serves pipelined instruction fetches from it.
module inst_mem_ctrl #(
    parameter int INST_MEM_WIDTH = 15
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic                      fetch_req,
    output logic [31:0]               inst,
    output logic                      inst_valid,
    output logic                      load_done,
    output logic [INST_MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_din,
    output logic                      mem_we,
    output logic                      mem_en,
    input  logic [31:0]               mem_dout
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [32:0] DEPTH = 33'd1 << INST_MEM_WIDTH;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] n_q, n_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        fetch_q, fetch_d;

    logic        byte_in;
    logic [31:0] asm_next;
    logic        in_range;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= HDR;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            n_q        <= 32'd0;
            idx_q      <= 32'd0;
            wdata_q    <= 32'd0;
            wr_q       <= 1'b0;
            fetch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            fetch_q    <= fetch_d;
        end
    end

    // The write is issued the cycle after a word completes, from its own data
    // register, so the assembler stays free to take the next byte at full rate.
    always_comb begin
        byte_in    = rx_valid && (state_q != RUN);
        asm_next   = {asm_q[23:0], rx_data};
        in_range   = ({1'b0, idx_q} < DEPTH);
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        n_d        = n_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        fetch_d    = (state_q == RUN) && fetch_req;

        if (byte_in) begin
            asm_d      = asm_next;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        case (state_q)
            HDR: begin
                if (byte_in && byte_cnt_q == 2'd3) begin
                    n_d     = asm_next;
                    idx_d   = 32'd0;
                    state_d = (asm_next == 32'd0) ? RUN : DATA;
                end
            end
            DATA: begin
                if (byte_in && byte_cnt_q == 2'd3) begin
                    wr_d    = 1'b1;
                    wdata_d = asm_next;
                end
                if (wr_q) begin
                    idx_d = idx_q + 32'd1;
                    if (idx_q + 32'd1 == n_q) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
            end
            default: state_d = HDR;
        endcase
    end

    // Memory port is shared: loader owns it until RUN, then the fetch path.
    always_comb begin
        load_done  = (state_q == RUN);
        inst       = mem_dout;
        inst_valid = fetch_q;
        mem_din    = wdata_q;
        if (state_q == RUN) begin
            mem_addr = pc;
            mem_en   = fetch_req;
            mem_we   = 1'b0;
        end else begin
            mem_addr = idx_q[INST_MEM_WIDTH-1:0];
            mem_we   = wr_q && in_range;
            mem_en   = wr_q && in_range;
        end
    end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: two instances (15-bit and 2-bit address) share one
// stimulus stream and are checked against a byte-stream reference model.
module tb_inst_mem_ctrl;

    localparam int WA = 15;
    localparam int WB = 2;

    logic          CLK = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [WA-1:0] pc;
    logic          fetch_req;

    logic [31:0]   inst_a, inst_b, mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;
    logic          inst_valid_a, inst_valid_b, load_done_a, load_done_b;
    logic          mem_we_a, mem_we_b, mem_en_a, mem_en_b;
    logic [WA-1:0] mem_addr_a;
    logic [WB-1:0] mem_addr_b;

    logic [31:0]   bram_a [0:(1<<WA)-1];
    logic [31:0]   bram_b [0:(1<<WB)-1];
    logic [31:0]   ref_a  [0:(1<<WA)-1];
    logic [31:0]   ref_b  [0:(1<<WB)-1];

    logic [31:0]   exp_a_q[$];
    logic [31:0]   exp_b_q[$];
    logic [7:0]    tx_q[$];
    logic [31:0]   wq[$];
    logic [WA-1:0] log_addr_a[$];
    logic [31:0]   log_data_a[$];
    logic [WB-1:0] log_addr_b[$];
    logic [31:0]   log_data_b[$];

    int            checks = 0;
    int            failures = 0;

    int            m_cnt;
    logic [31:0]   m_sh, m_n;
    bit            m_done, m_pend;

    inst_mem_ctrl #(.INST_MEM_WIDTH(WA)) dut_a (
        .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .pc(pc), .fetch_req(fetch_req), .inst(inst_a), .inst_valid(inst_valid_a),
        .load_done(load_done_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a),
        .mem_we(mem_we_a), .mem_en(mem_en_a), .mem_dout(mem_dout_a)
    );

    inst_mem_ctrl #(.INST_MEM_WIDTH(WB)) dut_b (
        .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .pc(pc[WB-1:0]), .fetch_req(fetch_req), .inst(inst_b), .inst_valid(inst_valid_b),
        .load_done(load_done_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b),
        .mem_we(mem_we_b), .mem_en(mem_en_b), .mem_dout(mem_dout_b)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_en_a) begin
            if (mem_we_a) bram_a[mem_addr_a] <= mem_din_a;
            mem_dout_a <= bram_a[mem_addr_a];
        end
        if (mem_en_b) begin
            if (mem_we_b) bram_b[mem_addr_b] <= mem_din_b;
            mem_dout_b <= bram_b[mem_addr_b];
        end
    end

    always @(negedge CLK) begin
        if (reset === 1'b1 && mem_we_a === 1'b1) begin
            log_addr_a.push_back(mem_addr_a);
            log_data_a.push_back(mem_din_a);
        end
        if (reset === 1'b1 && mem_we_b === 1'b1) begin
            log_addr_b.push_back(mem_addr_b);
            log_data_b.push_back(mem_din_b);
        end
    end

    task automatic clear_logs();
        log_addr_a.delete();
        log_data_a.delete();
        log_addr_b.delete();
        log_data_b.delete();
    endtask

    task automatic build_stream(input logic [31:0] n);
        logic [31:0] w;
        tx_q.delete();
        tx_q.push_back(n[31:24]);
        tx_q.push_back(n[23:16]);
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            tx_q.push_back(w[31:24]);
            tx_q.push_back(w[23:16]);
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
        end
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge.
    task automatic tick(input bit v, input logic [7:0] d, input bit fr, input logic [WA-1:0] p);
        bit            acc, wr_now, was_busy;
        int            prev_cnt, k;
        logic [31:0]   word, e_a, e_b;
        logic [WA-1:0] exp_addr;
        rx_valid  = v;
        rx_data   = d;
        fetch_req = fr;
        pc        = p;
        @(posedge CLK);
        acc = m_done && fr;
        if (acc) begin
            exp_a_q.push_back(ref_a[p]);
            exp_b_q.push_back(ref_b[p[WB-1:0]]);
        end
        was_busy = !m_done && !m_pend;
        prev_cnt = m_cnt;
        if (m_pend) begin
            m_done = 1'b1;
            m_pend = 1'b0;
        end
        wr_now = 1'b0;
        k      = 0;
        word   = 32'd0;
        if (v && was_busy) begin
            m_cnt++;
            m_sh = {m_sh[23:0], d};
            if (m_cnt == 4) begin
                m_n = m_sh;
                if (m_n == 32'd0) m_done = 1'b1;
            end else if (m_cnt > 4 && m_cnt % 4 == 0) begin
                wr_now = 1'b1;
                k      = (m_cnt - 4) / 4 - 1;
                word   = m_sh;
                ref_a[WA'(k)] = word;
                if (k < 4) ref_b[WB'(k)] = word;
                if (k + 1 == int'(m_n)) m_pend = 1'b1;
            end
        end
        exp_addr = WA'(((prev_cnt > 4) ? prev_cnt - 4 : 0) / 4);
        @(negedge CLK);

        checks++;
        if (load_done_a !== m_done || load_done_b !== m_done) begin
            failures++;
            $display("FAIL load_done: got a=%b b=%b, expected %b", load_done_a, load_done_b, m_done);
        end
        checks++;
        if (inst_valid_a !== acc || inst_valid_b !== acc) begin
            failures++;
            $display("FAIL inst_valid: got a=%b b=%b, expected %b", inst_valid_a, inst_valid_b, acc);
        end
        if (acc) begin
            e_a = exp_a_q.pop_front();
            e_b = exp_b_q.pop_front();
            checks++;
            if (inst_a !== e_a || inst_b !== e_b) begin
                failures++;
                $display("FAIL inst_data pc=%0d: got a=%h b=%h, expected a=%h b=%h", p, inst_a, inst_b, e_a, e_b);
            end
        end
        if (m_done) begin
            checks++;
            if (mem_we_a !== 1'b0 || mem_we_b !== 1'b0 || mem_en_a !== fr || mem_en_b !== fr ||
                mem_addr_a !== p || mem_addr_b !== p[WB-1:0]) begin
                failures++;
                $display("FAIL run_port: got we=%b/%b en=%b/%b addr=%0d/%0d, expected we=0 en=%b addr=%0d",
                         mem_we_a, mem_we_b, mem_en_a, mem_en_b, mem_addr_a, mem_addr_b, fr, p);
            end
        end else begin
            checks++;
            if (mem_we_a !== wr_now || mem_en_a !== wr_now || mem_addr_a !== exp_addr) begin
                failures++;
                $display("FAIL load_port_a: got we=%b en=%b addr=%0d, expected we=%b en=%b addr=%0d",
                         mem_we_a, mem_en_a, mem_addr_a, wr_now, wr_now, exp_addr);
            end
            if (wr_now) begin
                checks++;
                if (mem_din_a !== word) begin
                    failures++;
                    $display("FAIL wr_data_a word=%0d: got %h, expected %h", k, mem_din_a, word);
                end
            end
            checks++;
            if (mem_we_b !== (wr_now && k < 4) || mem_en_b !== (wr_now && k < 4)) begin
                failures++;
                $display("FAIL we_b word=%0d: got we=%b en=%b, expected %b", k, mem_we_b, mem_en_b, wr_now && k < 4);
            end
            if (wr_now && k < 4) begin
                checks++;
                if (mem_din_b !== word || mem_addr_b !== WB'(k)) begin
                    failures++;
                    $display("FAIL wr_b word=%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                             k, mem_addr_b, mem_din_b, k, word);
                end
            end
        end
    endtask

    task automatic send_stream(input int max_gap, input bit fetch_noise, input bit finish);
        logic [7:0] b;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            tick(1'b1, b, fetch_noise, WA'($urandom_range(0, 31)));
            repeat ($urandom_range(0, max_gap)) tick(1'b0, 8'($urandom), fetch_noise, WA'($urandom));
        end
        if (finish) begin
            for (int i = 0; i < 3 && !m_done; i++) tick(1'b0, 8'h00, 1'b0, '0);
            checks++;
            if (load_done_a !== 1'b1 || load_done_b !== 1'b1) begin
                failures++;
                $display("FAIL load_finish: got a=%b b=%b, expected 1", load_done_a, load_done_b);
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        rx_valid  = 1'b0;
        fetch_req = 1'b0;
        #1;
        checks++;
        if (load_done_a !== 1'b0 || inst_valid_a !== 1'b0 || mem_we_a !== 1'b0 || mem_en_a !== 1'b0 ||
            mem_din_a !== 32'd0 || mem_addr_a !== '0 || load_done_b !== 1'b0 || inst_valid_b !== 1'b0 ||
            mem_we_b !== 1'b0 || mem_en_b !== 1'b0 || mem_din_b !== 32'd0 || mem_addr_b !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got done=%b iv=%b we=%b en=%b din=%h addr=%0d, expected all 0",
                     load_done_a, inst_valid_a, mem_we_a, mem_en_a, mem_din_a, mem_addr_a);
        end
        @(posedge CLK);
        @(negedge CLK);
        reset  = 1'b1;
        m_cnt  = 0;
        m_sh   = 32'd0;
        m_n    = 32'd0;
        m_done = 1'b0;
        m_pend = 1'b0;
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick(1'b0, 8'h00, 1'b1, WA'(5));
        checks++;
        if (load_done_a !== 1'b0 || inst_valid_a !== 1'b0 || mem_addr_a !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got done=%b iv=%b addr=%0d, expected 0 0 0", load_done_a, inst_valid_a, mem_addr_a);
        end
    endtask

    task automatic test_two_words();
        logic [31:0] want [2];
        want[0] = 32'h11223344;
        want[1] = 32'hAABBCCDD;
        do_reset();
        clear_logs();
        wq.delete();
        wq.push_back(want[0]);
        wq.push_back(want[1]);
        build_stream(32'd2);
        send_stream(0, 1'b0, 1'b1);
        checks++;
        if (log_data_a.size() != 2) begin
            failures++;
            $display("FAIL two_words_count: got %0d writes, expected 2", log_data_a.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (log_addr_a[i] !== WA'(i) || log_data_a[i] !== want[i]) begin
                    failures++;
                    $display("FAIL two_words_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                             i, log_addr_a[i], log_data_a[i], i, want[i]);
                end
            end
        end
    endtask

    task automatic test_fetch();
        logic [WA-1:0] pcs  [3];
        logic [31:0]   want [3];
        pcs[0] = WA'(1); pcs[1] = WA'(0); pcs[2] = WA'(1);
        want[0] = 32'hAABBCCDD; want[1] = 32'h11223344; want[2] = 32'hAABBCCDD;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1, pcs[i]);
            checks++;
            if (inst_valid_a !== 1'b1 || inst_a !== want[i]) begin
                failures++;
                $display("FAIL fetch_seq[%0d]: got valid=%b inst=%h, expected valid=1 inst=%h", i, inst_valid_a, inst_a, want[i]);
            end
        end
        tick(1'b0, 8'h00, 1'b0, '0);
        checks++;
        if (inst_valid_a !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle: got valid=%b, expected 0", inst_valid_a);
        end
        repeat (30) tick(1'($urandom), 8'($urandom), 1'($urandom), WA'($urandom_range(0, 7)));
    endtask

    task automatic test_zero_len();
        do_reset();
        clear_logs();
        wq.delete();
        build_stream(32'd0);
        send_stream(0, 1'b0, 1'b0);
        checks++;
        if (load_done_a !== 1'b1 || log_data_a.size() != 0) begin
            failures++;
            $display("FAIL zero_len: got done=%b writes=%0d, expected done=1 writes=0", load_done_a, log_data_a.size());
        end
        repeat (4) tick(1'b1, 8'($urandom), 1'b0, '0);
    endtask

    task automatic test_fetch_during_load();
        do_reset();
        wq.delete();
        repeat (3) wq.push_back($urandom);
        build_stream(32'd3);
        send_stream(2, 1'b1, 1'b1);
        repeat (10) tick(1'b0, 8'h00, 1'b1, WA'($urandom_range(0, 3)));
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        clear_logs();
        tx_q.delete();
        tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h02);
        tx_q.push_back(8'hEE); tx_q.push_back(8'hFF);
        send_stream(0, 1'b0, 1'b0);
        do_reset();
        wq.delete();
        wq.push_back(32'h11223344);
        wq.push_back(32'hAABBCCDD);
        build_stream(32'd2);
        send_stream(0, 1'b0, 1'b1);
        checks++;
        if (log_data_a.size() != 2 || log_addr_a[0] !== WA'(0) || log_data_a[0] !== 32'h11223344 ||
            log_addr_a[1] !== WA'(1) || log_data_a[1] !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL reset_mid_load: got %0d writes, expected 2 at addr0=11223344 addr1=aabbccdd", log_data_a.size());
        end
        tick(1'b0, 8'h00, 1'b1, WA'(0));
        tick(1'b0, 8'h00, 1'b1, WA'(1));
    endtask

    task automatic test_overflow();
        do_reset();
        clear_logs();
        wq.delete();
        repeat (6) wq.push_back($urandom);
        build_stream(32'd6);
        send_stream(1, 1'b0, 1'b1);
        checks++;
        if (log_data_a.size() != 6 || log_data_b.size() != 4) begin
            failures++;
            $display("FAIL overflow_count: got a=%0d b=%0d writes, expected a=6 b=4", log_data_a.size(), log_data_b.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr_b[i] !== WB'(i) || log_data_b[i] !== wq[i]) begin
                    failures++;
                    $display("FAIL overflow_b[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                             i, log_addr_b[i], log_data_b[i], i, wq[i]);
                end
            end
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 8'h00, 1'b1, WA'(i));
        tick(1'b0, 8'h00, 1'b0, '0);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            n = $urandom_range(1, 5);
            wq.delete();
            repeat (n) wq.push_back($urandom);
            build_stream(32'(n));
            send_stream(it % 3, 1'($urandom), 1'b1);
            repeat (20) tick(1'($urandom), 8'($urandom), 1'($urandom), WA'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << WA); i++) begin
            bram_a[i] = 32'd0;
            ref_a[i]  = 32'd0;
        end
        for (int i = 0; i < (1 << WB); i++) begin
            bram_b[i] = 32'd0;
            ref_b[i]  = 32'd0;
        end
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        fetch_req = 1'b0;
        pc        = '0;
        @(negedge CLK);
        test_reset();
        test_two_words();
        test_fetch();
        test_zero_len();
        test_fetch_during_load();
        test_reset_mid_load();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation did not complete within time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_mem_ctrl.md
INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 The block SHALL have parameter INST_MEM_WIDTH, default 15, the instruction memory address width in words.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset; asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port rx_data  input  8  loader byte, valid only when rx_valid=1.
REQ-005 The block SHALL have port rx_valid  input  1  one-cycle strobe per received loader byte.
REQ-006 The block SHALL have port pc  input  INST_MEM_WIDTH  fetch word address.
REQ-007 The block SHALL have port fetch_req  input  1  fetch request for pc in this cycle.
REQ-008 The block SHALL have port inst  output  32  fetched instruction.
REQ-009 The block SHALL have port inst_valid  output  1  inst holds the word for the previous cycle's accepted fetch.
REQ-010 The block SHALL have port load_done  output  1  program load complete; level signal.
REQ-011 The block SHALL have port mem_addr  output  INST_MEM_WIDTH  BRAM address.
REQ-012 The block SHALL have port mem_din  output  32  BRAM write data.
REQ-013 The block SHALL have port mem_we  output  1  BRAM write enable.
REQ-014 The block SHALL have port mem_en  output  1  BRAM enable.
REQ-015 The block SHALL have port mem_dout  input  32  BRAM read data; 1-cycle read latency.

Function
REQ-016 The FSM SHALL have states HDR (collect 4 header bytes), DATA (collect instruction words), RUN (serve fetches).
REQ-017 In HDR and DATA, each rx_valid byte SHALL be shifted into a 32-bit assembler, big-endian (first byte = bits 31:24); a 2-bit byte counter wraps 3->0.
REQ-018 On the 4th header byte, the assembled value SHALL be latched as 32-bit word count N; if N=0 the FSM SHALL go to RUN next cycle, else to DATA with word index 0.
REQ-019 On each 4th data byte, the block SHALL drive mem_we=1, mem_en=1, mem_din=assembled word, mem_addr=word index[INST_MEM_WIDTH-1:0] for exactly one cycle.
REQ-020 The 32-bit word index SHALL increment after each completed word; writes with index >= 2^INST_MEM_WIDTH SHALL be dropped (mem_we=0), with no address wrap.
REQ-021 When the completed-word count equals N, the FSM SHALL enter RUN on the next cycle.
REQ-022 A byte arriving in the same cycle as a write SHALL be accepted into the assembler; no byte is lost at full rate.
REQ-023 In RUN, rx_valid SHALL be ignored; mem_we SHALL be 0.
REQ-024 In RUN, mem_addr SHALL equal pc combinationally and mem_en SHALL equal fetch_req.
REQ-025 In RUN, a fetch_req in cycle t SHALL produce inst_valid=1 in cycle t+1 with inst=mem_dout; fetches SHALL be pipelined at one per cycle.
REQ-026 In HDR and DATA, fetch_req SHALL be ignored, inst_valid SHALL be 0, and mem_addr SHALL hold the loader word index.
REQ-027 inst SHALL pass mem_dout through unchanged in all states; it is defined only when inst_valid=1.
REQ-028 load_done SHALL be 1 exactly while the FSM is in RUN.

Reset
REQ-029 While reset=0, the FSM SHALL be in HDR with the byte counter, word index, N and assembler cleared.
REQ-030 While reset=0, the block SHALL drive load_done=0, inst_valid=0, mem_we=0, mem_en=0, mem_din=0 and mem_addr=0.
REQ-031 Reset asserted mid-load SHALL discard partial bytes and words; the next byte after release SHALL be header byte 0.
REQ-032 Reset SHALL NOT clear BRAM contents.

Verification
REQ-033 The bench SHALL cover: bytes 00 00 00 02 11 22 33 44 AA BB CC DD -> writes addr0=0x11223344 and addr1=0xAABBCCDD, then load_done=1 the cycle after the 2nd write.
REQ-034 The bench SHALL cover: bytes 00 00 00 00 -> no mem_we, and load_done=1 the cycle after the 4th byte.
REQ-035 The bench SHALL cover: after REQ-033, fetch_req with pc=1,0,1 on consecutive cycles -> inst_valid=1 for 3 cycles with inst=0xAABBCCDD, 0x11223344, 0xAABBCCDD.
REQ-036 The bench SHALL cover: fetch_req=1 held during load -> inst_valid=0 throughout, and mem_addr tracks the word index rather than pc.
REQ-037 The bench SHALL cover: header N=2, then 2 data bytes, then reset pulse, then full sequence per REQ-033 -> only the post-reset words are written, at addr0 and addr1.
REQ-038 The bench SHALL cover: INST_MEM_WIDTH=2 with N=6 -> only addr0..3 are written, and load_done=1 only after all 6 words are received.
